// File: rtl/deathrace_pkg.sv
// Shared Death Race constants: sprite ROM arbiter defaults and sprite requester indices.
package deathrace_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int AW_DEF      = 12;
    localparam int DW_DEF      = 12;
    localparam int ROM_LAT_DEF = 2;

    typedef enum int {
        SPR_CAR        = 0,
        SPR_OBSTACLE   = 1,
        SPR_HUD        = 2,
        SPR_BACKGROUND = 3
    } sprite_id_e;

    localparam int REQ_CAR        = SPR_CAR;
    localparam int REQ_OBSTACLE   = SPR_OBSTACLE;
    localparam int REQ_HUD        = SPR_HUD;
    localparam int REQ_BACKGROUND = SPR_BACKGROUND;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Round-robin priority search: first active request at or after (ptr + 1) mod N_REQ.
module rr_pick
    import deathrace_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] win,
    output logic             any
);

    logic [PW-1:0] start;

    assign start = (ptr == PW'(N_REQ - 1)) ? '0 : ptr + 1'b1;

    always_comb begin
        int idx;
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(start) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!any && req[idx]) begin
                win[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shared sprite ROM arbiter: round-robin grant, registered ROM issue, tagged fixed-latency return.
module sprite_rom_arbiter
    import deathrace_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hold,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] req_addr,
    output logic [N_REQ-1:0]    gnt,
    output logic [AW-1:0]       rom_addr,
    output logic                rom_en,
    input  logic [DW-1:0]       rom_data,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic                busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req_eff;
    logic [N_REQ-1:0] win;
    logic             win_any;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    ptr;

    // Stage k of the tag/valid pipe is the read issued k cycles ago; stage 0 is the issue cycle.
    logic             vld_p [0:ROM_LAT];
    logic [PW-1:0]    tag_p [0:ROM_LAT];

    assign req_eff = hold ? '0 : req;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_rr_pick (
        .req (req_eff),
        .ptr (ptr),
        .win (win),
        .any (win_any)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) win_idx = PW'(i);
        end
    end

    // Issue stage: grant, ROM address and enable registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            rom_addr <= '0;
            ptr      <= PW'(N_REQ - 1);
            for (int k = 0; k <= ROM_LAT; k++) vld_p[k] <= 1'b0;
        end else begin
            gnt      <= win_any ? win : '0;
            vld_p[0] <= win_any;
            if (win_any) begin
                rom_addr <= req_addr[int'(win_idx)*AW +: AW];
                ptr      <= win_idx;
            end
            for (int k = 1; k <= ROM_LAT; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (win_any) tag_p[0] <= win_idx;
        for (int k = 1; k <= ROM_LAT; k++) tag_p[k] <= tag_p[k-1];
    end

    assign rom_en = vld_p[0];

    // Return stage: ROM word arrives ROM_LAT cycles after issue, steered by the carried tag.
    always_comb begin
        rvalid = '0;
        if (vld_p[ROM_LAT]) rvalid[tag_p[ROM_LAT]] = 1'b1;
    end

    assign rdata = vld_p[ROM_LAT] ? rom_data : '0;

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= ROM_LAT; k++) busy = busy | vld_p[k];
    end

endmodule
